// File: rtl/fpu_mmio_pkg.sv
// Shared definitions for the FPU MMIO responder: register map, command codes,
// enums, STATUS bit positions and timeout constants.
package fpu_mmio_pkg;

    localparam logic [12:0] ADR_OPA    = 13'h600;
    localparam logic [12:0] ADR_OPB    = 13'h604;
    localparam logic [12:0] ADR_CMD    = 13'h608;
    localparam logic [12:0] ADR_RESULT = 13'h60C;
    localparam logic [12:0] ADR_STATUS = 13'h610;

    localparam logic [31:0] CMD_ADD = 32'd1;
    localparam logic [31:0] CMD_SUB = 32'd2;
    localparam logic [31:0] CMD_MUL = 32'd3;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } fpu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_BAD_CMD = 3;
    localparam int ST_TIMEOUT = 4;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = $clog2(TIMEOUT);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic cmd_valid(input logic [31:0] c);
        return (c >= CMD_ADD) && (c <= CMD_MUL);
    endfunction

endpackage

// File: rtl/fpu_mmio_responder_if.sv
// Bus-side and FPU-core-side signals of the responder. The slave modport is the
// responder itself; master is whatever drives the bus and models the core.
interface fpu_mmio_responder_if;
    logic        MemWrite;
    logic [12:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        fpu_start;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_result;
    logic        fpu_valid;

    modport slave (
        input  MemWrite, DataAdr, WriteData, fpu_result, fpu_valid,
        output ReadData, fpu_start, fpu_op, fpu_a, fpu_b
    );

    modport master (
        output MemWrite, DataAdr, WriteData, fpu_result, fpu_valid,
        input  ReadData, fpu_start, fpu_op, fpu_a, fpu_b
    );
endinterface

// File: rtl/fpu_mmio_ctrl.sv
// Launch FSM (IDLE -> ISSUE -> WAIT -> IDLE) with WAIT timeout counter; emits
// one-cycle event strobes that the top uses to update RESULT and STATUS.
module fpu_mmio_ctrl
    import fpu_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cmd_wr,
    input  logic [31:0] i_cmd,
    input  logic        i_fpu_valid,
    output logic        o_fpu_start,
    output logic [1:0]  o_fpu_op,
    output logic        o_busy,
    output logic        o_launch,
    output logic        o_res_we,
    output logic        o_timeout,
    output logic        o_done,
    output logic        o_overrun,
    output logic        o_bad_cmd
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    fpu_op_e          r_op;
    logic             r_start;
    logic [CNT_W-1:0] r_cnt;
    logic             w_idle;
    logic             w_wait;

    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_wait    = (r_state == S_WAIT);
        o_launch  = i_cmd_wr && w_idle && cmd_valid(i_cmd);
        o_bad_cmd = i_cmd_wr && w_idle && !cmd_valid(i_cmd);
        o_overrun = i_cmd_wr && !w_idle;
        // A valid on the final WAIT cycle wins over the timeout.
        o_done    = w_wait && i_fpu_valid;
        o_timeout = w_wait && !i_fpu_valid && (r_cnt == CNT_LAST);
        o_res_we  = o_done || o_timeout;
        o_busy    = !w_idle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_ADD;
            r_start <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (o_launch) begin
                        r_state <= S_ISSUE;
                        r_start <= 1'b1;
                        r_op    <= fpu_op_e'(i_cmd[1:0] - 2'd1);
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    if (o_res_we) r_state <= S_IDLE;
                    else          r_cnt   <= r_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fpu_start = r_start;
    assign o_fpu_op    = r_op;

endmodule

// File: rtl/fpu_mmio_responder.sv
// Memory-mapped front end for a single-precision FPU core: operand/result
// registers, read mux, and (with FPU_MMIO_STATUS_EN) the STATUS register.
module fpu_mmio_responder
    import fpu_mmio_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    fpu_mmio_responder_if.slave  bus
);

    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_result;
    logic [31:0] r_fpu_a;
    logic [31:0] r_fpu_b;
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    logic w_wr_opa;
    logic w_wr_opb;
    logic w_wr_cmd;
    logic w_busy;
    logic w_launch;
    logic w_res_we;
    logic w_timeout;
    logic w_done;
    logic w_overrun;
    logic w_bad_cmd;

    assign w_wr_opa = bus.MemWrite && (bus.DataAdr == ADR_OPA);
    assign w_wr_opb = bus.MemWrite && (bus.DataAdr == ADR_OPB);
    assign w_wr_cmd = bus.MemWrite && (bus.DataAdr == ADR_CMD);

    fpu_mmio_ctrl u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .i_cmd_wr    (w_wr_cmd),
        .i_cmd       (bus.WriteData),
        .i_fpu_valid (bus.fpu_valid),
        .o_fpu_start (bus.fpu_start),
        .o_fpu_op    (bus.fpu_op),
        .o_busy      (w_busy),
        .o_launch    (w_launch),
        .o_res_we    (w_res_we),
        .o_timeout   (w_timeout),
        .o_done      (w_done),
        .o_overrun   (w_overrun),
        .o_bad_cmd   (w_bad_cmd)
    );

    // Operand copies are taken only at launch, so later OPA/OPB writes leave
    // the operation in flight untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_fpu_a  <= '0;
            r_fpu_b  <= '0;
        end else begin
            if (w_wr_opa) r_opa <= bus.WriteData;
            if (w_wr_opb) r_opb <= bus.WriteData;
            if (w_launch) begin
                r_fpu_a <= r_opa;
                r_fpu_b <= r_opb;
            end
            if (w_res_we) r_result <= w_timeout ? QNAN : bus.fpu_result;
        end
    end

`ifdef FPU_MMIO_STATUS_EN
    logic       r_done;
    logic [2:0] r_sticky;
    logic       w_wr_stat;
    logic [2:0] w_set;
    logic [2:0] w_clr;

    assign w_wr_stat = bus.MemWrite && (bus.DataAdr == ADR_STATUS);
    assign w_set     = {w_timeout, w_bad_cmd, w_overrun};
    assign w_clr     = w_wr_stat ? bus.WriteData[ST_TIMEOUT:ST_OVERRUN] : 3'b000;

    // Set has priority over a same-cycle write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done   <= 1'b0;
            r_sticky <= 3'b000;
        end else begin
            if (w_launch)    r_done <= 1'b0;
            else if (w_done) r_done <= 1'b1;
            r_sticky <= (r_sticky & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_status                          = '0;
        w_status[ST_BUSY]                 = w_busy;
        w_status[ST_DONE]                 = r_done;
        w_status[ST_TIMEOUT:ST_OVERRUN]   = r_sticky;
    end
`else
    logic w_unused_flags;

    assign w_unused_flags = w_busy | w_done | w_overrun | w_bad_cmd;
    assign w_status       = '0;
`endif

    always_comb begin
        case (bus.DataAdr)
            ADR_OPA:    w_rdata = r_opa;
            ADR_OPB:    w_rdata = r_opb;
            ADR_RESULT: w_rdata = r_result;
            ADR_STATUS: w_rdata = w_status;
            default:    w_rdata = '0;
        endcase
    end

    assign bus.ReadData = w_rdata;
    assign bus.fpu_a    = r_fpu_a;
    assign bus.fpu_b    = r_fpu_b;

endmodule

// File: tb/tb_fpu_mmio_responder.sv
// Directed bench for fpu_mmio_responder: register-map vector table plus
// hand-written launch, overrun, bad-command, timeout and reset sequences.
module tb_fpu_mmio_responder;
    import fpu_mmio_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fpu_mmio_responder_if bus();

    fpu_mmio_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          core_lat = 0;
    logic [31:0] core_ret = 32'h0;
    logic        inj_valid = 1'b0;
    logic        mdl_valid = 1'b0;
    int          mdl_cnt = 0;
    int          start_cnt = 0;
    int          s0;

    assign bus.fpu_valid  = mdl_valid | inj_valid;
    assign bus.fpu_result = core_ret;

    // Core model: sees start on the edge after ISSUE, raises valid core_lat edges later.
    always @(posedge clk) begin
        mdl_valid <= 1'b0;
        if (bus.fpu_start) start_cnt <= start_cnt + 1;
        if (bus.fpu_start && core_lat > 0) mdl_cnt <= core_lat;
        else if (mdl_cnt == 1) begin
            mdl_valid <= 1'b1;
            mdl_cnt   <= 0;
        end else if (mdl_cnt > 1) mdl_cnt <= mdl_cnt - 1;
    end

    typedef struct {
        logic        wr;
        logic [12:0] adr;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[11];

    function automatic logic [31:0] st(input logic [31:0] v);
`ifdef FPU_MMIO_STATUS_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    endtask

    task automatic rd_chk(input string name, input logic [12:0] a, input logic [31:0] exp);
        bus.DataAdr = a;
        #1;
        chk(name, bus.ReadData, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [12:0] a, input logic [31:0] d);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = a;
        bus.WriteData = d;
        @(posedge clk);
        #1;
        bus.MemWrite  = 1'b0;
    endtask

    initial begin
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;

        vt[0]  = '{1'b0, ADR_OPA,    32'h0,        32'h0,        "rst_opa"};
        vt[1]  = '{1'b0, ADR_OPB,    32'h0,        32'h0,        "rst_opb"};
        vt[2]  = '{1'b0, ADR_RESULT, 32'h0,        32'h0,        "rst_result"};
        vt[3]  = '{1'b0, ADR_STATUS, 32'h0,        32'h0,        "rst_status"};
        vt[4]  = '{1'b1, ADR_OPA,    32'h40600000, 32'h40600000, "wr_opa"};
        vt[5]  = '{1'b1, ADR_OPB,    32'h40100000, 32'h40100000, "wr_opb"};
        vt[6]  = '{1'b0, ADR_CMD,    32'h0,        32'h0,        "cmd_reads0"};
        vt[7]  = '{1'b1, 13'h614,    32'hDEADBEEF, 32'h0,        "unmapped"};
        vt[8]  = '{1'b1, ADR_RESULT, 32'h12345678, 32'h0,        "result_ro"};
        vt[9]  = '{1'b0, 13'h602,    32'h0,        32'h0,        "unaligned"};
        vt[10] = '{1'b0, ADR_OPA,    32'h0,        32'h40600000, "opa_kept"};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_start", {31'h0, bus.fpu_start}, 32'h0);
        chk("rst_op",    {30'h0, bus.fpu_op},    32'h0);
        chk("rst_fpu_a", bus.fpu_a, 32'h0);
        chk("rst_fpu_b", bus.fpu_b, 32'h0);

        for (int i = 0; i < 11; i++) begin
            if (vt[i].wr) bus_wr(vt[i].adr, vt[i].wd);
            rd_chk(vt[i].name, vt[i].adr, vt[i].exp);
        end

        // ADD with core latency 2: RESULT lands exactly 4 edges after CMD.
        core_lat = 2;
        core_ret = 32'h40B80000;
        s0 = start_cnt;
        bus_wr(ADR_CMD, 32'd1);
        chk("add_start", {31'h0, bus.fpu_start}, 32'h1);
        chk("add_op",    {30'h0, bus.fpu_op},    32'h0);
        chk("add_a",     bus.fpu_a, 32'h40600000);
        chk("add_b",     bus.fpu_b, 32'h40100000);
        rd_chk("add_busy", ADR_STATUS, st(32'h1));
        tick(3);
        rd_chk("add_res_e3", ADR_RESULT, 32'h0);
        tick(1);
        rd_chk("add_res_e4", ADR_RESULT, 32'h40B80000);
        chk("add_nstart", start_cnt - s0, 32'd1);
        rd_chk("add_status", ADR_STATUS, st(32'h2));

        // MUL, then a dropped SUB and an OPA write while in flight.
        core_lat = 3;
        core_ret = 32'h42C80000;
        bus_wr(ADR_OPA, 32'h41200000);
        bus_wr(ADR_OPB, 32'h41200000);
        s0 = start_cnt;
        bus_wr(ADR_CMD, 32'd3);
        chk("mul_op", {30'h0, bus.fpu_op}, 32'h2);
        bus_wr(ADR_CMD, 32'd2);
        bus_wr(ADR_OPA, 32'h3F800000);
        chk("mul_a_held", bus.fpu_a, 32'h41200000);
        tick(2);
        rd_chk("mul_res_e4", ADR_RESULT, 32'h40B80000);
        tick(1);
        rd_chk("mul_res_e5", ADR_RESULT, 32'h42C80000);
        chk("mul_nstart", start_cnt - s0, 32'd1);
        chk("mul_op_kept", {30'h0, bus.fpu_op}, 32'h2);
        rd_chk("mul_status", ADR_STATUS, st(32'h6));
        rd_chk("opa_new", ADR_OPA, 32'h3F800000);
        bus_wr(ADR_STATUS, 32'h4);
        rd_chk("ovr_clr", ADR_STATUS, st(32'h2));

        // Bad commands and a stray valid while idle.
        s0 = start_cnt;
        bus_wr(ADR_CMD, 32'd7);
        tick(2);
        chk("bad7_nstart", start_cnt - s0, 32'd0);
        rd_chk("bad7_res", ADR_RESULT, 32'h42C80000);
        rd_chk("bad7_status", ADR_STATUS, st(32'hA));
        bus_wr(ADR_STATUS, 32'h8);
        rd_chk("bad_clr", ADR_STATUS, st(32'h2));
        bus_wr(ADR_CMD, 32'd0);
        tick(2);
        chk("bad0_nstart", start_cnt - s0, 32'd0);
        rd_chk("bad0_status", ADR_STATUS, st(32'hA));
        bus_wr(ADR_STATUS, 32'h8);
        core_ret  = 32'hCAFEF00D;
        inj_valid = 1'b1;
        tick(1);
        inj_valid = 1'b0;
        tick(1);
        rd_chk("stray_valid", ADR_RESULT, 32'h42C80000);

        // Timeout: 16 WAIT cycles, STATUS clear coinciding with the timeout edge.
        core_lat = 0;
        bus_wr(ADR_CMD, 32'd1);
        tick(16);
        rd_chk("to_res_e16", ADR_RESULT, 32'h42C80000);
        rd_chk("to_busy_e16", ADR_STATUS, st(32'h1));
        bus_wr(ADR_STATUS, 32'h10);
        rd_chk("to_res_e17", ADR_RESULT, QNAN);
        rd_chk("to_status", ADR_STATUS, st(32'h10));
        bus_wr(ADR_STATUS, 32'h10);
        rd_chk("to_clr", ADR_STATUS, st(32'h0));

        // Reset while in WAIT, then a late valid.
        core_ret = 32'h12345678;
        bus_wr(ADR_CMD, 32'd2);
        tick(2);
        rd_chk("rw_busy", ADR_STATUS, st(32'h1));
        reset = 1'b1;
        tick(1);
        reset     = 1'b0;
        inj_valid = 1'b1;
        tick(1);
        inj_valid = 1'b0;
        tick(1);
        rd_chk("rw_result", ADR_RESULT, 32'h0);
        rd_chk("rw_status", ADR_STATUS, 32'h0);
        rd_chk("rw_opa", ADR_OPA, 32'h0);
        chk("rw_fpu_a", bus.fpu_a, 32'h0);
        chk("rw_op", {30'h0, bus.fpu_op}, 32'h0);
        chk("rw_start", {31'h0, bus.fpu_start}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
